// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the traffic_controller block.
//   state_e    - 3-bit controller state encoding (also exported on state_dbg)
//   LAMP_*     - one-hot lamp encodings, bit order {R,Y,G}
//   max_u      - unsigned max, used to size the seconds counter
//   main_lamp  - main-street lamp pattern for a given state
//   side_lamp  - side-street lamp pattern for a given state
package traffic_pkg;

  typedef enum logic [2:0] {
    StMainG1 = 3'd0,
    StMainG2 = 3'd1,
    StMainY  = 3'd2,
    StWalk   = 3'd3,
    StSideG1 = 3'd4,
    StSideGx = 3'd5,
    StSideY  = 3'd6
  } state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [2:0] main_lamp(input state_e s);
    logic [2:0] lamp;
    case (s)
      StMainG1, StMainG2: lamp = LAMP_G;
      StMainY:            lamp = LAMP_Y;
      default:            lamp = LAMP_R;
    endcase
    return lamp;
  endfunction

  function automatic logic [2:0] side_lamp(input state_e s);
    logic [2:0] lamp;
    case (s)
      StSideG1, StSideGx: lamp = LAMP_G;
      StSideY:            lamp = LAMP_Y;
      default:            lamp = LAMP_R;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-second tick divider.
// Counts 0..CLK_HZ-1 and raises tick for the single cycle in which the count
// sits at CLK_HZ-1, so the first tick after reset is in cycle CLK_HZ.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears the divider to 0
//   tick - one-cycle pulse every CLK_HZ cycles
module tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DivW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_HZ - 1);

  if (CLK_HZ == 0) begin : g_bad_clk_hz
    $error("tick_gen: CLK_HZ must be nonzero");
  end

  logic [DivW-1:0] div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (div_q == DivMax) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  assign tick = (div_q == DivMax);

endmodule

// File: rtl/traffic_controller.sv
// traffic_controller: two-way intersection controller with sensor-extended
// greens and an optional pedestrian walk phase.
// Build option: define PED_WALK_EN to include the walk request latch and the
// WALK state; without it WalkEn is ignored and WalkLight stays 0.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   WalkEn    - pedestrian request (debounced, synchronous)
//   Sensor    - side-street traffic present (level)
//   MainLight - main-street lamps {R,Y,G}, one-hot
//   SideLight - side-street lamps {R,Y,G}, one-hot
//   WalkLight - pedestrian walk lamp
//   state_dbg - current state encoding
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned T_BASE = 6,
  parameter int unsigned T_EXT  = 3,
  parameter int unsigned T_YEL  = 2,
  parameter int unsigned T_WALK = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       WalkEn,
  input  logic       Sensor,
  output logic [2:0] MainLight,
  output logic [2:0] SideLight,
  output logic       WalkLight,
  output logic [2:0] state_dbg
);

  localparam int unsigned MaxDur = max_u(max_u(T_BASE, T_EXT), max_u(T_YEL, T_WALK));
  localparam int unsigned CntW   = $clog2(MaxDur) + 1;

  localparam logic [CntW-1:0] DurBase = CntW'(T_BASE);
  localparam logic [CntW-1:0] DurExt  = CntW'(T_EXT);
  localparam logic [CntW-1:0] DurYel  = CntW'(T_YEL);
  localparam logic [CntW-1:0] DurWalk = CntW'(T_WALK);

  // A zero duration would never reach the expiry count of 1.
  if (T_BASE == 0 || T_EXT == 0 || T_YEL == 0 || T_WALK == 0) begin : g_bad_duration
    $error("traffic_controller: all duration parameters must be nonzero");
  end

  logic tick;

  tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            walk_req;

`ifdef PED_WALK_EN
  logic walk_req_q, walk_req_d;
  assign walk_req = walk_req_q;
`else
  logic unused_walk_en;
  assign walk_req       = 1'b0;
  assign unused_walk_en = WalkEn;
`endif

  // Next state and counter. Sensor and walk_req only matter in the expiring
  // tick cycle, so changes between ticks are ignored by construction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (cnt_q == CntW'(1)) begin
        case (state_q)
          StMainG1: begin
            state_d = StMainG2;
            cnt_d   = Sensor ? DurExt : DurBase;
          end
          StMainG2: begin
            state_d = StMainY;
            cnt_d   = DurYel;
          end
          StMainY: begin
            if (walk_req) begin
              state_d = StWalk;
              cnt_d   = DurWalk;
            end else begin
              state_d = StSideG1;
              cnt_d   = DurBase;
            end
          end
`ifdef PED_WALK_EN
          StWalk: begin
            state_d = StSideG1;
            cnt_d   = DurBase;
          end
`endif
          StSideG1: begin
            if (Sensor) begin
              state_d = StSideGx;
              cnt_d   = DurExt;
            end else begin
              state_d = StSideY;
              cnt_d   = DurYel;
            end
          end
          StSideGx: begin
            state_d = StSideY;
            cnt_d   = DurYel;
          end
          default: begin
            state_d = StMainG1;
            cnt_d   = DurBase;
          end
        endcase
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

`ifdef PED_WALK_EN
  // Entry into WALK consumes the request; a request arriving on that same
  // cycle is lost on purpose, and requests during WALK are not latched.
  always_comb begin
    walk_req_d = walk_req_q;
    if (WalkEn && (state_q != StWalk)) begin
      walk_req_d = 1'b1;
    end
    if ((state_d == StWalk) && (state_q != StWalk)) begin
      walk_req_d = 1'b0;
    end
  end
`endif

  // Lamps are registered from the next state so they always match state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StMainG1;
      cnt_q      <= DurBase;
      MainLight  <= LAMP_G;
      SideLight  <= LAMP_R;
`ifdef PED_WALK_EN
      walk_req_q <= 1'b0;
      WalkLight  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      MainLight  <= main_lamp(state_d);
      SideLight  <= side_lamp(state_d);
`ifdef PED_WALK_EN
      walk_req_q <= walk_req_d;
      WalkLight  <= (state_d == StWalk);
`endif
    end
  end

`ifndef PED_WALK_EN
  assign WalkLight = 1'b0;
`endif

  assign state_dbg = state_q;

endmodule

// File: tb/tb_traffic_controller.sv
// Bench for traffic_controller with CLK_HZ=4, so one second is 4 cycles.
// Expected state segments (state, length in cycles) are queued per scenario and
// popped whenever the observed state changes; lamps are checked every cycle.
module tb_traffic_controller;
  import traffic_pkg::*;

  logic       clk;
  logic       rst;
  logic       WalkEn;
  logic       Sensor;
  logic [2:0] MainLight;
  logic [2:0] SideLight;
  logic       WalkLight;
  logic [2:0] state_dbg;

  traffic_controller #(
    .CLK_HZ (4),
    .T_BASE (6),
    .T_EXT  (3),
    .T_YEL  (2),
    .T_WALK (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .WalkEn    (WalkEn),
    .Sensor    (Sensor),
    .MainLight (MainLight),
    .SideLight (SideLight),
    .WalkLight (WalkLight),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    state_e st;
    int     len;
  } exp_t;

  typedef struct {
    int     scen;
    state_e st;
    int     len;
  } seg_rec_t;

  typedef struct {
    string  name;
    int     smode;   // 0: Sensor=0, 1: Sensor=1, 2: toggled outside tick cycles
    int     wmode;   // 0: none, 1: one-cycle pulse early in MAIN_G1, 2: held in MAIN_Y/WALK
  } scen_t;

  seg_rec_t segs[$];
  scen_t    scens[$];
  exp_t     exp_q[$];

  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  logic [2:0] seg_state;
  int       seg_len;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Lamp patterns {Main, Side, Walk} written from the state/lamp table.
  function automatic int exp_lamps(input logic [2:0] s);
    case (s)
      StMainG1, StMainG2: return {3'b001, 3'b100, 1'b0};
      StMainY:            return {3'b010, 3'b100, 1'b0};
      StWalk:             return {3'b100, 3'b100, 1'b1};
      StSideG1, StSideGx: return {3'b100, 3'b001, 1'b0};
      StSideY:            return {3'b100, 3'b010, 1'b0};
      default:            return -1;
    endcase
  endfunction

  task automatic add(input int sc, input state_e st, input int len);
    seg_rec_t r;
    r.scen = sc;
    r.st   = st;
    r.len  = len;
    segs.push_back(r);
  endtask

  task automatic push_exp(input state_e st, input int len);
    exp_t e;
    e.st  = st;
    e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic close_seg();
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL seg_extra: got state %0d len %0d want no further segment", seg_state,
               seg_len);
    end else begin
      e = exp_q.pop_front();
      chk("seg_state", int'(seg_state), int'(e.st));
      chk("seg_len", seg_len, e.len);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    chk("lamps", int'({MainLight, SideLight, WalkLight}), exp_lamps(state_dbg));
    if (state_dbg == seg_state) begin
      seg_len++;
    end else begin
      close_seg();
      seg_state = state_dbg;
      seg_len   = 1;
    end
  endtask

  // Reset is held across exactly one rising edge; the sample after it is cycle 1.
  task automatic do_reset(input string nm);
    rst = 1'b1;
    @(negedge clk);
    chk({nm, "_state"}, int'(state_dbg), int'(StMainG1));
    chk({nm, "_main"}, int'(MainLight), 3'b001);
    chk({nm, "_side"}, int'(SideLight), 3'b100);
    chk({nm, "_walk"}, int'(WalkLight), 0);
    rst       = 1'b0;
    cyc       = 1;
    seg_state = state_dbg;
    seg_len   = 1;
    exp_q.delete();
  endtask

  task automatic run_scen(input string nm, input int smode, input int wmode,
                          input state_e end_st);
    int budget = 16;
    int n = 0;
    bit saw_walk = 1'b0;
    foreach (exp_q[i]) budget += exp_q[i].len;
    while (exp_q.size() != 0 && budget > 0) begin
      // Values driven now are seen at the edge closing cycle cyc; ticks fall on cyc%4==0.
      case (smode)
        0:       Sensor = 1'b0;
        1:       Sensor = 1'b1;
        default: Sensor = (cyc % 4 == 0) ? 1'b0 : 1'b1;
      endcase
      case (wmode)
        1: WalkEn = (n == 2);
        2: begin
          if (state_dbg == StWalk) saw_walk = 1'b1;
          WalkEn = (state_dbg == StMainY || state_dbg == StWalk) &&
                   !(saw_walk && state_dbg != StWalk);
        end
        default: WalkEn = 1'b0;
      endcase
      step();
      n++;
      budget--;
    end
    WalkEn = 1'b0;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d segments outstanding want 0", nm, exp_q.size());
      exp_q.delete();
    end
    chk({nm, "_end_state"}, int'(state_dbg), int'(end_st));
  endtask

  initial begin
    rst    = 1'b1;
    Sensor = 1'b0;
    WalkEn = 1'b0;
    seg_state = 3'd0;
    seg_len   = 0;

    scens.push_back('{"plain", 0, 0});
    add(0, StMainG1, 24); add(0, StMainG2, 24); add(0, StMainY, 8);
    add(0, StSideG1, 24); add(0, StSideY, 8);

    scens.push_back('{"sensor", 1, 0});
    add(1, StMainG1, 24); add(1, StMainG2, 12); add(1, StMainY, 8);
    add(1, StSideG1, 24); add(1, StSideGx, 12); add(1, StSideY, 8);

    scens.push_back('{"sens_toggle", 2, 0});
    add(2, StMainG1, 24); add(2, StMainG2, 24); add(2, StMainY, 8);
    add(2, StSideG1, 24); add(2, StSideY, 8);

`ifdef PED_WALK_EN
    scens.push_back('{"walk_pulse", 0, 1});
    add(3, StMainG1, 24); add(3, StMainG2, 24); add(3, StMainY, 8); add(3, StWalk, 12);
    add(3, StSideG1, 24); add(3, StSideY, 8);
    add(3, StMainG1, 24); add(3, StMainG2, 24); add(3, StMainY, 8);
    add(3, StSideG1, 24); add(3, StSideY, 8);

    scens.push_back('{"walk_held", 0, 2});
    add(4, StMainG1, 24); add(4, StMainG2, 24); add(4, StMainY, 8); add(4, StWalk, 12);
    add(4, StSideG1, 24); add(4, StSideY, 8);
    add(4, StMainG1, 24); add(4, StMainG2, 24); add(4, StMainY, 8);
    add(4, StSideG1, 24); add(4, StSideY, 8);
`else
    scens.push_back('{"walk_disabled", 0, 1});
    add(3, StMainG1, 24); add(3, StMainG2, 24); add(3, StMainY, 8);
    add(3, StSideG1, 24); add(3, StSideY, 8);
`endif

    do_reset("reset");

    for (int s = 0; s < scens.size(); s++) begin
      foreach (segs[i]) begin
        if (segs[i].scen == s) push_exp(segs[i].st, segs[i].len);
      end
      run_scen(scens[s].name, scens[s].smode, scens[s].wmode, StMainG1);
    end

    // Reset in the middle of SIDE_G1: MAIN_G1 must then last a full 24 cycles,
    // which needs both the counter and the divider restarted.
    push_exp(StMainG1, 24); push_exp(StMainG2, 24); push_exp(StMainY, 8);
    run_scen("pre_reset", 0, 0, StSideG1);
    repeat (5) step();
    chk("mid_state", int'(state_dbg), int'(StSideG1));
    do_reset("mid_reset");
    push_exp(StMainG1, 24);
    run_scen("post_reset", 0, 0, StMainG2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a wait above ever stops making progress.
  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t want finish before it", $time);
    $fatal(1, "global timeout");
  end

endmodule
